// File: rtl/uart_rx_irq.sv
// uart_rx_irq: 8N1 oversampling UART receiver feeding a first-word-fall-through byte FIFO with a level IRQ.
// Optional idle-timeout interrupt is built only when UART_RX_TIMEOUT_IRQ_EN is defined.
module uart_rx_irq #(
    parameter int unsigned CLK_DIV_W    = 16,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned THRESH       = 1,
    parameter int unsigned TIMEOUT_BITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx,
    input  logic [CLK_DIV_W-1:0]   clk_div,
    input  logic                   irq_en,
    input  logic                   rd_en,
    output logic [7:0]             rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] level,
    output logic                   frame_err,
    output logic                   overrun,
    input  logic                   err_clr,
    output logic                   irq
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;
    localparam int unsigned MIN_DIV = 4;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || THRESH == 0 || THRESH > DEPTH ||
        TIMEOUT_BITS == 0) begin : g_bad_params
        $error("uart_rx_irq: illegal parameter combination");
    end

    // Two-flop synchronizer plus one delay stage for falling-edge detection
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    logic                 fall_c;
    logic [CLK_DIV_W-1:0] div_eff_c;

    assign fall_c    = rx_prev & ~rx_sync;
    assign div_eff_c = (clk_div < CLK_DIV_W'(MIN_DIV)) ? CLK_DIV_W'(MIN_DIV) : clk_div;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [CLK_DIV_W-1:0] cnt;
    logic [CLK_DIV_W-1:0] cnt_n;
    logic [CLK_DIV_W-1:0] div_q;
    logic [CLK_DIV_W-1:0] div_n;
    logic [2:0]           bit_idx;
    logic [2:0]           bit_n;
    logic [7:0]           shreg;
    logic [7:0]           shreg_n;
    logic                 push_c;
    logic                 frame_set_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            div_q   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            div_q   <= div_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
        end
    end

    // Receive sequencing: divisor is latched at start detect so clk_div changes only affect later frames
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        div_n       = div_q;
        bit_n       = bit_idx;
        shreg_n     = shreg;
        push_c      = 1'b0;
        frame_set_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall_c) begin
                    div_n   = div_eff_c;
                    cnt_n   = div_eff_c >> 1;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (cnt == '0) begin
                    if (rx_sync) begin
                        state_n = S_IDLE;
                    end else begin
                        cnt_n   = div_q - CLK_DIV_W'(1);
                        bit_n   = '0;
                        state_n = S_DATA;
                    end
                end else begin
                    cnt_n = cnt - CLK_DIV_W'(1);
                end
            end
            S_DATA: begin
                if (cnt == '0) begin
                    shreg_n = {rx_sync, shreg[7:1]};
                    cnt_n   = div_q - CLK_DIV_W'(1);
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt - CLK_DIV_W'(1);
                end
            end
            S_STOP: begin
                if (cnt == '0) begin
                    push_c      = rx_sync;
                    frame_set_c = ~rx_sync;
                    state_n     = S_IDLE;
                end else begin
                    cnt_n = cnt - CLK_DIV_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_c;
    logic             full_c;
    logic             wr_c;
    logic             ovr_set_c;
    logic [LVL_W-1:0] level_n;
    logic [7:0]       head_n;

    assign pop_c     = rd_en & rd_valid;
    assign full_c    = (level == LVL_W'(DEPTH));
    assign wr_c      = push_c & (~full_c | pop_c);
    assign ovr_set_c = push_c & full_c & ~pop_c;
    assign level_n   = level + LVL_W'(wr_c) - LVL_W'(pop_c);

    // Next head byte: the freshly received byte lands directly at the head when it becomes the only entry
    always_comb begin
        head_n = rd_data;
        if (level_n == '0) begin
            head_n = 8'h00;
        end else if (pop_c) begin
            head_n = (level == LVL_W'(1)) ? shreg : mem[rd_ptr + PTR_W'(1)];
        end else if (level == '0) begin
            head_n = shreg;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
        end else begin
            wr_ptr   <= wr_ptr + PTR_W'(wr_c);
            rd_ptr   <= rd_ptr + PTR_W'(pop_c);
            level    <= level_n;
            rd_valid <= (level_n != '0);
            rd_data  <= head_n;
        end
    end

    // Sticky error flags; clearing wins over a coincident set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (err_clr) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_err | frame_set_c;
            overrun   <= overrun | ovr_set_c;
        end
    end

    logic timeout;

`ifdef UART_RX_TIMEOUT_IRQ_EN
    localparam int unsigned TO_W = CLK_DIV_W + $clog2(TIMEOUT_BITS + 1);

    logic            start_c;
    logic            have_div;
    logic [TO_W-1:0] idle_cnt;
    logic [TO_W-1:0] to_limit_c;

    assign start_c    = (state == S_IDLE) & fall_c;
    assign to_limit_c = TO_W'(TIMEOUT_BITS) * TO_W'(have_div ? div_q : div_eff_c);

    // Idle timer counts only while parked in IDLE with unread data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_div <= 1'b0;
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (start_c) begin
                have_div <= 1'b1;
            end
            if (pop_c | start_c | err_clr) begin
                idle_cnt <= '0;
                timeout  <= 1'b0;
            end else if ((state == S_IDLE) && (level != '0) && !timeout) begin
                if (idle_cnt >= to_limit_c - TO_W'(1)) begin
                    timeout <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + TO_W'(1);
                end
            end
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_en & ((level >= LVL_W'(THRESH)) | frame_err | overrun | timeout);
        end
    end

endmodule
